// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding/hazard unit.
// Defines the operand-select encodings, the tracking-entry layout and the writer-match helper.
package fwd_hazard_unit_pkg;

    localparam int unsigned REG_AW = 6;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;
    localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              wrEn;
        logic              isLoad;
    } trackEntry_t;

    localparam trackEntry_t BUBBLE = '0;

    // Register 0 is hardwired, so it never forwards and never stalls.
    function automatic logic writerMatches(input trackEntry_t e, input logic [REG_AW-1:0] src);
        return e.valid && e.wrEn && (e.dst != '0) && (e.dst == src);
    endfunction

endpackage

// File: rtl/fwd_operand_resolve.sv
// Resolves one ALU operand against the EX and MEM tracking entries.
// Produces the next-cycle operand select and flags a load-use hazard.
module fwd_operand_resolve
    import fwd_hazard_unit_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  trackEntry_t       e1,
    input  trackEntry_t       e2,
    output logic [SEL_W-1:0]  sel,
    output logic              hazard
);

    // The EX entry is checked first because it holds the newest value.
    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (used) begin
            if (writerMatches(e1, src)) begin
                if (e1.isLoad) begin
                    hazard = 1'b1;
                end else begin
                    sel = SEL_EXMEM;
                end
            end else if (writerMatches(e2, src)) begin
                sel = SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// RAW hazard detection and forwarding-select generation for the EX-stage ALU operands.
// Tracks the EX and MEM writers, issues selects one cycle ahead, and stalls on load-use.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              a_ctrlA,
    output logic              a_ctrlB,
    output logic              b_ctrlA,
    output logic              b_ctrlB,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trackEntry_t      e1;
    trackEntry_t      e2;
    logic [SEL_W-1:0] selA;
    logic [SEL_W-1:0] selB;
    logic             hazA;
    logic             hazB;
    logic             insertBubble;

    fwd_operand_resolve uResolveA (
        .src    (id_rs),
        .used   (id_valid && id_rs_used),
        .e1     (e1),
        .e2     (e2),
        .sel    (selA),
        .hazard (hazA)
    );

    fwd_operand_resolve uResolveB (
        .src    (id_rt),
        .used   (id_valid && id_rt_used),
        .e1     (e1),
        .e2     (e2),
        .sel    (selB),
        .hazard (hazB)
    );

    // A flush squashes the ID instruction, so it overrides any hazard.
    always_comb begin
        stall        = id_valid && !flush && (hazA || hazB);
        insertBubble = stall || flush || !id_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e1          <= BUBBLE;
            e2          <= BUBBLE;
            ex_valid    <= 1'b0;
            a_ctrlA     <= 1'b0;
            a_ctrlB     <= 1'b0;
            b_ctrlA     <= 1'b0;
            b_ctrlB     <= 1'b0;
            stall_count <= '0;
        end else begin
            e2 <= e1;
            if (insertBubble) begin
                e1       <= BUBBLE;
                ex_valid <= 1'b0;
                a_ctrlA  <= 1'b0;
                a_ctrlB  <= 1'b0;
                b_ctrlA  <= 1'b0;
                b_ctrlB  <= 1'b0;
            end else begin
                e1       <= '{valid: 1'b1, dst: id_dst, wrEn: id_wr_en, isLoad: id_is_load};
                ex_valid <= 1'b1;
                a_ctrlA  <= selA[1];
                a_ctrlB  <= selA[0];
                b_ctrlA  <= selB[1];
                b_ctrlB  <= selB[0];
            end
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed vectors push expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fwd_hazard_unit;

    localparam int unsigned AW = 6;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic          stall;
        logic          exValid;
        logic [1:0]    selA;
        logic [1:0]    selB;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          idValid;
    logic [AW-1:0] idRs;
    logic [AW-1:0] idRt;
    logic          idRsUsed;
    logic          idRtUsed;
    logic [AW-1:0] idDst;
    logic          idWrEn;
    logic          idIsLoad;
    logic          flush;
    logic          stall;
    logic          exValid;
    logic          aCtrlA;
    logic          aCtrlB;
    logic          bCtrlA;
    logic          bCtrlB;
    logic [CW-1:0] stallCount;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    fwd_hazard_unit #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (idValid),
        .id_rs       (idRs),
        .id_rt       (idRt),
        .id_rs_used  (idRsUsed),
        .id_rt_used  (idRtUsed),
        .id_dst      (idDst),
        .id_wr_en    (idWrEn),
        .id_is_load  (idIsLoad),
        .flush       (flush),
        .stall       (stall),
        .ex_valid    (exValid),
        .a_ctrlA     (aCtrlA),
        .a_ctrlB     (aCtrlB),
        .b_ctrlA     (bCtrlA),
        .b_ctrlB     (bCtrlB),
        .stall_count (stallCount)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int vec, input logic [CW-1:0] act,
                              input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, vec, act, exp);
        end
    endtask

    // Monitor: the observation point for every cycle is the falling edge.
    int vecIdx = 0;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkField("stall",       vecIdx, CW'(stall),              CW'(e.stall));
            checkField("ex_valid",    vecIdx, CW'(exValid),            CW'(e.exValid));
            checkField("sel_a",       vecIdx, CW'({aCtrlA, aCtrlB}),   CW'(e.selA));
            checkField("sel_b",       vecIdx, CW'({bCtrlA, bCtrlB}),   CW'(e.selB));
            checkField("stall_count", vecIdx, stallCount,              e.cnt);
            vecIdx++;
        end
    end

    // Drive one cycle of ID inputs; expected values are what the monitor sees this cycle:
    // stall from these inputs, registered outputs from the previous edge.
    task automatic step(input logic r, input logic v, input int rs, input logic rsU,
                        input int rt, input logic rtU, input int dst, input logic wr,
                        input logic ld, input logic fl, input logic eStall, input logic eExv,
                        input logic [1:0] eA, input logic [1:0] eB, input int eCnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        idValid  = v;
        idRs     = AW'(rs);
        idRsUsed = rsU;
        idRt     = AW'(rt);
        idRtUsed = rtU;
        idDst    = AW'(dst);
        idWrEn   = wr;
        idIsLoad = ld;
        flush    = fl;
        e.stall   = eStall;
        e.exValid = eExv;
        e.selA    = eA;
        e.selB    = eB;
        e.cnt     = CW'(eCnt);
        expQ.push_back(e);
    endtask

    task automatic idle(input logic eExv, input logic [1:0] eA, input logic [1:0] eB,
                        input int eCnt);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eExv, eA, eB, eCnt);
    endtask

    initial begin
        rst = 1'b1; idValid = 1'b0; idRs = '0; idRt = '0; idRsUsed = 1'b0; idRtUsed = 1'b0;
        idDst = '0; idWrEn = 1'b0; idIsLoad = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 2'b00, 2'b00, 0);
        // Back-to-back dependent ALU: r5 then rs=r5
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0,    0, 0, 2'b00, 2'b00, 0);
        step(0, 1, 5, 1, 0, 0, 10, 1, 0, 0,   0, 1, 2'b00, 2'b00, 0);
        idle(1, 2'b01, 2'b00, 0);
        // Distance-2: r7, unrelated, rt=r7
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,    0, 0, 2'b00, 2'b00, 0);
        step(0, 1, 1, 1, 0, 0, 12, 1, 0, 0,   0, 1, 2'b00, 2'b00, 0);
        step(0, 1, 0, 0, 7, 1, 13, 1, 0, 0,   0, 1, 2'b00, 2'b00, 0);
        // Both older write r3; consumer reads r3 on both operands
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0,    0, 1, 2'b00, 2'b10, 0);
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0,    0, 1, 2'b00, 2'b00, 0);
        step(0, 1, 3, 1, 3, 1, 14, 1, 0, 0,   0, 1, 2'b00, 2'b00, 0);
        idle(1, 2'b01, 2'b01, 0);
        idle(0, 2'b00, 2'b00, 0);
        // Load-use on r9: one stall cycle, then MEM/WB select
        step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0,    0, 0, 2'b00, 2'b00, 0);
        step(0, 1, 9, 1, 0, 0, 15, 1, 0, 0,   1, 1, 2'b00, 2'b00, 0);
        step(0, 1, 9, 1, 0, 0, 15, 1, 0, 0,   0, 0, 2'b00, 2'b00, 1);
        idle(1, 2'b10, 2'b00, 1);
        // Register 0: ALU writer, then load writer, never forwards or stalls
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,    0, 0, 2'b00, 2'b00, 1);
        step(0, 1, 0, 1, 0, 1, 16, 1, 0, 0,   0, 1, 2'b00, 2'b00, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0,    0, 1, 2'b00, 2'b00, 1);
        step(0, 1, 0, 1, 0, 0, 17, 1, 0, 0,   0, 1, 2'b00, 2'b00, 1);
        idle(1, 2'b00, 2'b00, 1);
        // Flush during load-use: no stall, bubble inserted
        step(0, 1, 0, 0, 0, 0, 20, 1, 1, 0,   0, 0, 2'b00, 2'b00, 1);
        step(0, 1, 20, 1, 0, 0, 21, 1, 0, 1,  0, 1, 2'b00, 2'b00, 1);
        idle(0, 2'b00, 2'b00, 1);
        // Load-use on operand B, then reset while the consumer is still in ID
        step(0, 1, 0, 0, 0, 0, 22, 1, 1, 0,   0, 0, 2'b00, 2'b00, 1);
        step(0, 1, 0, 0, 22, 1, 23, 1, 0, 0,  1, 1, 2'b00, 2'b00, 1);
        step(1, 1, 0, 0, 22, 1, 23, 1, 0, 0,  0, 0, 2'b00, 2'b00, 2);
        step(0, 1, 0, 0, 22, 1, 23, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        idle(1, 2'b00, 2'b00, 0);
        // Operands match different entries
        step(0, 1, 0, 0, 0, 0, 30, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0);
        step(0, 1, 0, 0, 0, 0, 31, 1, 0, 0,   0, 1, 2'b00, 2'b00, 0);
        step(0, 1, 30, 1, 31, 1, 32, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        idle(1, 2'b10, 2'b01, 0);
        // Matching register but operand not used
        step(0, 1, 0, 0, 0, 0, 33, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0);
        step(0, 1, 33, 0, 33, 0, 34, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        idle(1, 2'b00, 2'b00, 0);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog time=%0t want=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
